// File: rtl/msg_pkg.sv
// Shared message-FIFO types: field widths, the 40-bit message record and the
// drain-side FSM states, plus the checksum helper used by the transmitter.
// Used by the FIFO wrapper, msg_fifo_tx and the bench.
package msg_pkg;

  localparam int MSG_FIELDS = 5;
  localparam int FIELD_W    = 8;

  // Field order matches transmit byte order (al_dl goes out first).
  typedef struct packed {
    logic [FIELD_W-1:0] al_dl;
    logic [FIELD_W-1:0] d_id;
    logic [FIELD_W-1:0] s_id;
    logic [FIELD_W-1:0] m_addr;
    logic [FIELD_W-1:0] m_data;
  } msg_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2
  } tx_state_t;

  // Frame checksum: XOR of all five message fields.
  function automatic logic [FIELD_W-1:0] msg_chk(input msg_t m);
    return m.al_dl ^ m.d_id ^ m.s_id ^ m.m_addr ^ m.m_data;
  endfunction

endpackage

// File: rtl/msg_fifo_tx.sv
// Purpose: pops one message from the FIFO and sends it as a 5/6-byte framed stream.
// Latency: first byte valid 2 cycles after fifo_read; 7 (CHK_EN=0) / 8 (CHK_EN=1) cycles per frame.
// Backpressure: tx_ready low stalls the byte with tx_data/sof/eof held; no pop until the frame ends.
// Ports: clk/reset (async, active-high); fifo_empty/fifo_read and the five head
// fields from the FIFO read port; tx_data/tx_valid/tx_sof/tx_eof/tx_ready byte
// link; busy (not IDLE); msg_count (completed frames, wraps).
module msg_fifo_tx
  import msg_pkg::*;
#(
  parameter int CHK_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_empty,
  output logic             fifo_read,
  input  logic [7:0]       Al_Dl_101,
  input  logic [7:0]       D_ID,
  input  logic [7:0]       S_ID,
  input  logic [7:0]       M_Addr,
  input  logic [7:0]       M_Data,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  output logic             tx_sof,
  output logic             tx_eof,
  input  logic             tx_ready,
  output logic             busy,
  output logic [CNT_W-1:0] msg_count
);

  // Index of the final byte in the frame.
  localparam logic [2:0] LP_LAST = 3'(4 + CHK_EN);

  tx_state_t        r_state;
  tx_state_t        w_state_nxt;
  msg_t             r_msg;
  logic [7:0]       r_chk;
  logic [2:0]       r_idx;
  logic [CNT_W-1:0] r_count;

  msg_t             w_head;
  logic [7:0]       w_byte;
  logic             w_hs;

  assign w_head = '{al_dl: Al_Dl_101, d_id: D_ID, s_id: S_ID, m_addr: M_Addr, m_data: M_Data};

  // Byte select on the frame index.
  always_comb begin
    w_byte = '0;
    case (r_idx)
      3'd0:    w_byte = r_msg.al_dl;
      3'd1:    w_byte = r_msg.d_id;
      3'd2:    w_byte = r_msg.s_id;
      3'd3:    w_byte = r_msg.m_addr;
      3'd4:    w_byte = r_msg.m_data;
      3'd5:    w_byte = r_chk;
      default: w_byte = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    fifo_read   = 1'b0;
    tx_valid    = 1'b0;
    tx_sof      = 1'b0;
    tx_eof      = 1'b0;
    tx_data     = '0;
    busy        = 1'b1;
    w_hs        = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        // Gated by reset so every output reads 0 while reset is held.
        fifo_read = !fifo_empty && !reset;
        if (!fifo_empty) begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        // FIFO output registers present the popped entry this cycle.
        w_state_nxt = SEND;
      end
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = w_byte;
        tx_sof   = (r_idx == 3'd0);
        tx_eof   = (r_idx == LP_LAST);
        w_hs     = tx_ready;
        if (tx_ready && (r_idx == LP_LAST)) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_msg   <= '0;
      r_chk   <= '0;
      r_idx   <= '0;
      r_count <= '0;
    end else begin
      if (r_state == WAIT) begin
        r_msg <= w_head;
        r_chk <= msg_chk(w_head);
        r_idx <= '0;
      end else if (w_hs) begin
        if (r_idx == LP_LAST) begin
          r_idx   <= '0;
          r_count <= r_count + 1'b1;
        end else begin
          r_idx <= r_idx + 3'd1;
        end
      end
    end
  end

  assign msg_count = r_count;

endmodule

// File: tb/tb_msg_fifo_tx.sv
// Bench for msg_fifo_tx: instance A (CHK_EN=1, CNT_W=16) and instance B
// (CHK_EN=0, CNT_W=4), each fed by a small FIFO model, checked per cycle
// against an expected byte-stream queue built from each pushed message.
module tb_msg_fifo_tx;
  import msg_pkg::*;

  typedef struct packed {
    logic [7:0] d;
    logic       sof;
    logic       eof;
  } eb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rdy_a, rdy_b;
  logic rd_fl_a, rd_fl_b, empty_a, empty_b;
  logic vld_a, vld_b, sof_a, sof_b, eof_a, eof_b, bsy_a, bsy_b;
  logic [7:0] dat_a, dat_b;
  logic [15:0] cnt_a;
  logic [3:0] cnt_b;

  // FIFO models: pop sampled at the clock edge, head valid the cycle after.
  msg_t mem_a[64];
  msg_t mem_b[64];
  int wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;
  msg_t head_a = '0, head_b = '0;
  assign empty_a = (wr_a == rd_a);
  assign empty_b = (wr_b == rd_b);

  always @(posedge clk) begin
    if (rd_fl_a && (wr_a != rd_a)) begin
      head_a <= mem_a[rd_a % 64];
      rd_a   <= rd_a + 1;
    end
    if (rd_fl_b && (wr_b != rd_b)) begin
      head_b <= mem_b[rd_b % 64];
      rd_b   <= rd_b + 1;
    end
  end

  msg_fifo_tx #(.CHK_EN(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(rst_a), .fifo_empty(empty_a), .fifo_read(rd_fl_a),
    .Al_Dl_101(head_a.al_dl), .D_ID(head_a.d_id), .S_ID(head_a.s_id),
    .M_Addr(head_a.m_addr), .M_Data(head_a.m_data),
    .tx_data(dat_a), .tx_valid(vld_a), .tx_sof(sof_a), .tx_eof(eof_a),
    .tx_ready(rdy_a), .busy(bsy_a), .msg_count(cnt_a)
  );

  msg_fifo_tx #(.CHK_EN(0), .CNT_W(4)) dut_b (
    .clk(clk), .reset(rst_b), .fifo_empty(empty_b), .fifo_read(rd_fl_b),
    .Al_Dl_101(head_b.al_dl), .D_ID(head_b.d_id), .S_ID(head_b.s_id),
    .M_Addr(head_b.m_addr), .M_Data(head_b.m_data),
    .tx_data(dat_b), .tx_valid(vld_b), .tx_sof(sof_b), .tx_eof(eof_b),
    .tx_ready(rdy_b), .busy(bsy_b), .msg_count(cnt_b)
  );

  // Reference model state.
  eb_t  exp_a[$];
  eb_t  exp_b[$];
  msg_t pend_a[$];
  msg_t pend_b[$];
  int   frames_a = 0, frames_b = 0;
  int   acc_a = 0, acc_b = 0;
  bit   stall_a = 1'b0, stall_b = 1'b0;
  int   mode_a = 0, mode_b = 0, ph = 0;
  int   errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic msg_t rand_msg();
    msg_t m;
    m.al_dl  = 8'($urandom);
    m.d_id   = 8'($urandom);
    m.s_id   = 8'($urandom);
    m.m_addr = 8'($urandom);
    m.m_data = 8'($urandom);
    return m;
  endfunction

  // Queue a message for the FIFO and append its expected frame bytes.
  task automatic add_msg(input bit sel, input msg_t m);
    logic [7:0] b[6];
    int n;
    eb_t e;
    b[0] = m.al_dl;
    b[1] = m.d_id;
    b[2] = m.s_id;
    b[3] = m.m_addr;
    b[4] = m.m_data;
    b[5] = m.al_dl ^ m.d_id ^ m.s_id ^ m.m_addr ^ m.m_data;
    n = sel ? 5 : 6;
    for (int i = 0; i < n; i++) begin
      e.d   = b[i];
      e.sof = (i == 0);
      e.eof = (i == n - 1);
      if (sel) exp_b.push_back(e);
      else     exp_a.push_back(e);
    end
    if (sel) pend_b.push_back(m);
    else     pend_a.push_back(m);
  endtask

  function automatic logic next_rdy(input int mode, input int p);
    if (mode == 1) return ((p % 4) == 0) || ((p % 4) == 3);
    if (mode == 2) return ($urandom % 2) == 1;
    return 1'b1;
  endfunction

  task automatic check_dut(input bit sel);
    logic v, s, e, r, b, rd;
    logic [7:0] d;
    logic [31:0] c, fr;
    int wr, rp;
    eb_t x;
    string p;
    bit st;
    if (!sel) begin
      v = vld_a; s = sof_a; e = eof_a; r = rdy_a; b = bsy_a; rd = rd_fl_a; d = dat_a;
      c = 32'(cnt_a); fr = 32'(frames_a) & 32'hFFFF; wr = wr_a; rp = rd_a; st = stall_a; p = "A.";
    end else begin
      v = vld_b; s = sof_b; e = eof_b; r = rdy_b; b = bsy_b; rd = rd_fl_b; d = dat_b;
      c = 32'(cnt_b); fr = 32'(frames_b) & 32'hF; wr = wr_b; rp = rd_b; st = stall_b; p = "B.";
    end
    if (!b) chk({p, "fifo_read_idle"}, 32'(rd), 32'(wr != rp));
    else    chk({p, "fifo_read_busy"}, 32'(rd), 32'd0);
    chk({p, "msg_count"}, c, fr);
    if (st) chk({p, "hold_valid"}, 32'(v), 32'd1);
    if (v) begin
      if ((sel ? exp_b.size() : exp_a.size()) == 0) begin
        chk({p, "spurious_valid"}, 32'(v), 32'd0);
      end else begin
        x = sel ? exp_b[0] : exp_a[0];
        chk({p, "tx_data"}, 32'(d), 32'(x.d));
        chk({p, "tx_sof"}, 32'(s), 32'(x.sof));
        chk({p, "tx_eof"}, 32'(e), 32'(x.eof));
        if (r) begin
          if (sel) begin
            void'(exp_b.pop_front());
            acc_b = x.sof ? 1 : acc_b + 1;
            if (x.eof) frames_b++;
          end else begin
            void'(exp_a.pop_front());
            acc_a = x.sof ? 1 : acc_a + 1;
            if (x.eof) frames_a++;
          end
        end
      end
    end
    if (sel) stall_b = v && !r;
    else     stall_a = v && !r;
  endtask

  // One clock: inputs change 1 time unit after the rising edge, checks on the falling edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    while (pend_a.size() > 0) begin
      mem_a[wr_a % 64] = pend_a.pop_front();
      wr_a++;
    end
    while (pend_b.size() > 0) begin
      mem_b[wr_b % 64] = pend_b.pop_front();
      wr_b++;
    end
    rdy_a = next_rdy(mode_a, ph);
    rdy_b = next_rdy(mode_b, ph);
    ph++;
    @(negedge clk);
    check_dut(1'b0);
    check_dut(1'b1);
  endtask

  // Run until both streams drain; report first fifo_read, first valid and idle cycles for sel.
  task automatic run(input bit sel, input int budget, output int t_rd, output int t_v, output int t_end);
    int n;
    bit done;
    t_rd = -1; t_v = -1; t_end = -1; n = 0; done = 1'b0;
    while (!done && n < budget) begin
      cycle();
      if (t_rd < 0 && (sel ? rd_fl_b : rd_fl_a)) t_rd = n;
      if (t_v < 0 && (sel ? vld_b : vld_a)) t_v = n;
      if (exp_a.size() == 0 && exp_b.size() == 0 && pend_a.size() == 0 && pend_b.size() == 0
          && !bsy_a && !bsy_b) begin
        done = 1'b1;
        t_end = n;
      end
      n++;
    end
    if (!done) chk("drain_timeout", 32'(exp_a.size() + exp_b.size()), 32'd0);
  endtask

  initial begin
    int t_rd, t_v, t_end, p0;
    msg_t m0;
    bit hit;
    rst_a = 1'b1; rst_b = 1'b1; rdy_a = 1'b1; rdy_b = 1'b1;
    #1;
    chk("A.reset_valid", 32'(vld_a), 32'd0);
    chk("A.reset_data", 32'(dat_a), 32'd0);
    chk("A.reset_sof_eof", {30'd0, sof_a, eof_a}, 32'd0);
    chk("A.reset_busy_read", {30'd0, bsy_a, rd_fl_a}, 32'd0);
    chk("A.reset_count", 32'(cnt_a), 32'd0);
    chk("B.reset_outputs", {22'd0, vld_b, dat_b, bsy_b}, 32'd0);
    chk("B.reset_count", 32'(cnt_b), 32'd0);
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;

    // Single message, with checksum.
    m0 = '{al_dl: 8'h11, d_id: 8'h22, s_id: 8'h33, m_addr: 8'h44, m_data: 8'h55};
    add_msg(1'b0, m0);
    run(1'b0, 40, t_rd, t_v, t_end);
    chk("A.first_byte_latency", 32'(t_v - t_rd), 32'd2);
    chk("A.frame_cycles", 32'(t_end - t_rd), 32'd8);
    chk("A.single_pops", 32'(rd_a), 32'd1);
    chk("A.single_count", 32'(cnt_a), 32'd1);

    // Same message, no checksum.
    add_msg(1'b1, m0);
    run(1'b1, 40, t_rd, t_v, t_end);
    chk("B.first_byte_latency", 32'(t_v - t_rd), 32'd2);
    chk("B.frame_cycles", 32'(t_end - t_rd), 32'd7);
    chk("B.single_count", 32'(cnt_b), 32'd1);

    // Backpressure: fixed 1,0,0,1 pattern, then random.
    mode_a = 1;
    for (int i = 0; i < 3; i++) add_msg(1'b0, rand_msg());
    run(1'b0, 200, t_rd, t_v, t_end);
    mode_a = 2;
    for (int i = 0; i < 4; i++) add_msg(1'b0, rand_msg());
    run(1'b0, 300, t_rd, t_v, t_end);
    chk("A.bp_count", 32'(cnt_a), 32'd8);
    mode_a = 0;

    // Three messages back to back at full rate.
    p0 = rd_a;
    for (int i = 0; i < 3; i++) add_msg(1'b0, rand_msg());
    run(1'b0, 60, t_rd, t_v, t_end);
    chk("A.b2b_pops", 32'(rd_a - p0), 32'd3);
    chk("A.b2b_cycles", 32'(t_end - t_rd), 32'd24);
    chk("A.b2b_count", 32'(cnt_a), 32'd11);

    // Reset after byte 2 of a frame is accepted.
    add_msg(1'b0, rand_msg());
    add_msg(1'b0, rand_msg());
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      cycle();
      if (acc_a == 3) hit = 1'b1;
    end
    chk("A.reach_byte2", 32'(hit), 32'd1);
    @(posedge clk);
    #1;
    rst_a = 1'b1;
    #1;
    chk("A.rst_mid_valid", 32'(vld_a), 32'd0);
    chk("A.rst_mid_data", 32'(dat_a), 32'd0);
    chk("A.rst_mid_flags", {29'd0, sof_a, eof_a, rd_fl_a}, 32'd0);
    chk("A.rst_mid_busy", 32'(bsy_a), 32'd0);
    chk("A.rst_mid_count", 32'(cnt_a), 32'd0);
    while (exp_a.size() > 0 && !exp_a[0].sof) void'(exp_a.pop_front());
    frames_a = 0; stall_a = 1'b0; acc_a = 0;
    @(negedge clk);
    rst_a = 1'b0;
    run(1'b0, 40, t_rd, t_v, t_end);
    chk("A.after_reset_count", 32'(cnt_a), 32'd1);

    // Counter wrap on the 4-bit instance.
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    frames_b = 0;
    @(negedge clk);
    chk("B.rst_count", 32'(cnt_b), 32'd0);
    rst_b = 1'b0;
    p0 = rd_a;
    for (int i = 0; i < 17; i++) add_msg(1'b1, rand_msg());
    run(1'b1, 400, t_rd, t_v, t_end);
    chk("B.wrap_count", 32'(cnt_b), 32'd1);
    chk("A.idle_no_pops", 32'(rd_a - p0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/msg_fifo_tx.md
# msg_fifo_tx

Drain side of the 40-bit message FIFO. Pops one message at a time (fields Al_Dl_101, D_ID, S_ID, M_Addr, M_Data), latches it, and transmits it as a framed byte stream with an optional XOR checksum over a valid/ready link. It sits between the FIFO's read port and the downstream byte-wide link.

## Interface
- CHK_EN, 1: 1 appends an XOR checksum byte (6-byte frame); 0 gives a 5-byte frame.
- CNT_W, 16: width of the sent-message counter.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- fifo_empty  in  1  FIFO empty flag (my_empty_flag).
- fifo_read  out  1  pop request to FIFO (my_read_flag).
- Al_Dl_101  in  8  FIFO head field 0.
- D_ID  in  8  FIFO head field 1.
- S_ID  in  8  FIFO head field 2.
- M_Addr  in  8  FIFO head field 3.
- M_Data  in  8  FIFO head field 4.
- tx_data  out  8  link byte.
- tx_valid  out  1  tx_data is valid.
- tx_sof  out  1  first byte of frame, qualified by tx_valid.
- tx_eof  out  1  last byte of frame, qualified by tx_valid.
- tx_ready  in  1  downstream accepts the byte.
- busy  out  1  high in every state except IDLE.
- msg_count  out  CNT_W  frames fully sent, wraps modulo 2^CNT_W.

## Operation
- States: IDLE, WAIT, SEND.
- IDLE:
  - fifo_read = !fifo_empty (combinational, this state only).
  - If !fifo_empty, go to WAIT; otherwise stay in IDLE.
- WAIT:
  - FIFO output registers hold the popped entry.
  - At the exiting edge, latch {Al_Dl_101, D_ID, S_ID, M_Addr, M_Data} into msg_reg.
  - Latch chk = XOR of the five fields.
  - Set idx = 0 and go to SEND.
- SEND:
  - tx_valid = 1; tx_data = byte[idx].
  - Byte order: Al_Dl_101, D_ID, S_ID, M_Addr, M_Data, then chk if CHK_EN=1.
  - tx_sof = (idx==0); tx_eof = (idx==LAST), where LAST = 4 + CHK_EN.
  - Handshake tx_valid&&tx_ready with idx<LAST: idx++.
  - Handshake with idx==LAST: msg_count++ and go to IDLE.
- fifo_read is never asserted outside IDLE, so there is exactly one pop per frame.
- Under backpressure (tx_ready=0), tx_data, tx_sof and tx_eof hold stable; tx_valid never drops without a handshake.
- Reset mid-frame: state goes to IDLE immediately and all outputs go to 0. A message already popped is dropped; msg_count is not incremented for it.

## Timing
- Reset values: fifo_read=0, tx_valid=0, tx_sof=0, tx_eof=0, tx_data=0, busy=0, msg_count=0, idx=0, msg_reg=0.
- Read latency: pop sampled at edge E; FIFO fields are valid during the cycle after E; captured at edge E+1.
- First byte is valid one cycle after WAIT, i.e. 2 cycles after fifo_read is first high.
- Full throughput (tx_ready=1): 8 cycles per frame with CHK_EN=1, 7 with CHK_EN=0 (IDLE + WAIT + bytes). Pop and send do not overlap.
- Non-empty FIFO after a frame: IDLE lasts exactly one cycle, with fifo_read high in that cycle.
- fifo_empty is only sampled in IDLE; its value in WAIT/SEND is ignored.
- msg_count updates on the edge of the final handshake.

## Structure
- Package msg_pkg:
  - MSG_FIELDS=5, FIELD_W=8.
  - typedef struct packed msg_t {al_dl, d_id, s_id, m_addr, m_data}.
  - typedef enum tx_state_t {IDLE, WAIT, SEND}.
  - Shared with the FIFO wrapper and the bench.
- No sub-module; the checksum is a single XOR reduction and the byte select is a mux on idx (3 bits).

## Test plan
- Single message {11,22,33,44,55} hex, CHK_EN=1, tx_ready=1 -> bytes 11,22,33,44,55,11 (chk=11^22^33^44^55); sof on byte 0, eof on byte 5; one fifo_read pulse; msg_count=1; busy low 8 cycles after the pop.
- Same message, CHK_EN=0 -> bytes 11..55, eof on 55, 7-cycle frame, no checksum byte.
- tx_ready toggled 1,0,0,1,... -> each byte held stable while stalled, no duplicates or skips, order intact.
- Three messages queued back-to-back -> exactly 3 fifo_read pulses, each preceded by a completed frame; frames contiguous except the IDLE/WAIT gap; msg_count=3.
- Reset asserted after byte 2 is accepted -> outputs 0 immediately, state IDLE; the next queued message sends a complete frame; msg_count excludes the aborted frame.
- CNT_W=4 with 17 messages -> msg_count wraps to 1; FIFO empty throughout -> fifo_read never asserted, tx_valid stays 0.
